// File: rtl/xilinx_spdistram_arbiter.sv
// Two-requester round-robin arbiter/sequencer for a single-port distributed LUT RAM
// (positive-edge write, asynchronous read). One access per WCLK cycle, registered
// read data returned one cycle after the grant.
// Optional feature macro: SPDISTRAM_ARB_CLEAR_EN -- zero-fill sweep of the RAM after reset.
module xilinx_spdistram_arbiter #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  WCLK,
  input  logic                  RST_N,
  input  logic                  REQ0_VALID,
  output logic                  REQ0_READY,
  input  logic                  REQ0_WE,
  input  logic [ADDR_WIDTH-1:0] REQ0_A,
  input  logic [DATA_WIDTH-1:0] REQ0_D,
  output logic                  RSP0_VALID,
  output logic [DATA_WIDTH-1:0] RSP0_D,
  input  logic                  REQ1_VALID,
  output logic                  REQ1_READY,
  input  logic                  REQ1_WE,
  input  logic [ADDR_WIDTH-1:0] REQ1_A,
  input  logic [DATA_WIDTH-1:0] REQ1_D,
  output logic                  RSP1_VALID,
  output logic [DATA_WIDTH-1:0] RSP1_D,
  output logic                  RAM_WE,
  output logic [ADDR_WIDTH-1:0] RAM_A,
  output logic [DATA_WIDTH-1:0] RAM_D,
  input  logic [DATA_WIDTH-1:0] RAM_O,
  output logic                  BUSY
);

  localparam int NUM_REQ = 2;

  typedef enum logic {S_RUN = 1'b0, S_CLEAR = 1'b1} state_t;

  // requesters gathered into packed arrays so the datapath is indexed by lane
  logic [NUM_REQ-1:0]                 w_vld, w_we, w_gnt;
  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] w_a;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] w_d;

  assign w_vld = {REQ1_VALID, REQ0_VALID};
  assign w_we  = {REQ1_WE, REQ0_WE};
  assign w_a   = {REQ1_A, REQ0_A};
  assign w_d   = {REQ1_D, REQ0_D};

  state_t                             r_state, w_state_nxt;
  logic                               r_last_grant;
  logic [ADDR_WIDTH-1:0]              r_last_addr;
  logic [NUM_REQ-1:0]                 r_rsp_vld;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] r_rsp_d;

  logic                  w_ram_we, w_busy, w_clr_done;
  logic [ADDR_WIDTH-1:0] w_ram_a, w_clr_a;
  logic [DATA_WIDTH-1:0] w_ram_d;

`ifdef SPDISTRAM_ARB_CLEAR_EN
  localparam state_t RST_STATE = S_CLEAR;
  logic [ADDR_WIDTH-1:0] r_clr_cnt;

  // sweep address counter; wraps back to 0 on the last word
  always_ff @(posedge WCLK or negedge RST_N) begin
    if (!RST_N)                 r_clr_cnt <= '0;
    else if (r_state == S_CLEAR) r_clr_cnt <= r_clr_cnt + 1'b1;
  end

  assign w_clr_done = (r_clr_cnt == '1);
  assign w_clr_a    = r_clr_cnt;
`else
  localparam state_t RST_STATE = S_RUN;
  assign w_clr_done = 1'b1;
  assign w_clr_a    = '0;
`endif

  // state register
  always_ff @(posedge WCLK or negedge RST_N) begin
    if (!RST_N) r_state <= RST_STATE;
    else        r_state <= w_state_nxt;
  end

  // next state, round-robin grant and RAM port mux; nothing is granted while in reset
  always_comb begin
    w_state_nxt = r_state;
    w_gnt       = '0;
    w_ram_we    = 1'b0;
    w_ram_a     = r_last_addr;
    w_ram_d     = '0;
    w_busy      = 1'b0;
    case (r_state)
      S_CLEAR: begin
        w_busy   = 1'b1;
        w_ram_we = RST_N;
        w_ram_a  = w_clr_a;
        if (w_clr_done) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        if (RST_N) begin
          // req0 wins a tie only when req1 had the last grant
          if (w_vld[0] && (!w_vld[1] || r_last_grant)) w_gnt = 2'b01;
          else if (w_vld[1])                           w_gnt = 2'b10;
        end
        if (w_gnt[0]) begin
          w_ram_we = w_we[0];
          w_ram_a  = w_a[0];
          w_ram_d  = w_d[0];
        end else if (w_gnt[1]) begin
          w_ram_we = w_we[1];
          w_ram_a  = w_a[1];
          w_ram_d  = w_d[1];
        end
      end
      default: w_state_nxt = S_RUN;
    endcase
  end

  // round-robin pointer and the address held on the RAM during idle cycles
  always_ff @(posedge WCLK or negedge RST_N) begin
    if (!RST_N) begin
      r_last_grant <= 1'b1;
      r_last_addr  <= '0;
    end else if (|w_gnt) begin
      r_last_grant <= w_gnt[1];
      r_last_addr  <= w_ram_a;
    end
  end

  // read responses: capture the async RAM output at the end of the grant cycle
  always_ff @(posedge WCLK or negedge RST_N) begin
    if (!RST_N) begin
      r_rsp_vld <= '0;
      r_rsp_d   <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        r_rsp_vld[i] <= w_gnt[i] & ~w_we[i];
        if (w_gnt[i] && !w_we[i]) r_rsp_d[i] <= RAM_O;
      end
    end
  end

  assign REQ0_READY = w_gnt[0];
  assign REQ1_READY = w_gnt[1];
  assign RSP0_VALID = r_rsp_vld[0];
  assign RSP1_VALID = r_rsp_vld[1];
  assign RSP0_D     = r_rsp_d[0];
  assign RSP1_D     = r_rsp_d[1];
  assign RAM_WE     = w_ram_we;
  assign RAM_A      = w_ram_a;
  assign RAM_D      = w_ram_d;
  assign BUSY       = w_busy;

endmodule

// File: tb/tb_xilinx_spdistram_arbiter.sv
// Directed bench for xilinx_spdistram_arbiter with a behavioural LUT RAM model.
// Table-driven per-cycle vectors in the default build; the post-reset clear sweep
// sequence runs when SPDISTRAM_ARB_CLEAR_EN is defined.
module tb_xilinx_spdistram_arbiter;
  localparam int AW = 6;
  localparam int DW = 8;

  logic          WCLK = 1'b0;
  logic          RST_N;
  logic          REQ0_VALID, REQ0_READY, REQ0_WE, RSP0_VALID;
  logic [AW-1:0] REQ0_A;
  logic [DW-1:0] REQ0_D, RSP0_D;
  logic          REQ1_VALID, REQ1_READY, REQ1_WE, RSP1_VALID;
  logic [AW-1:0] REQ1_A;
  logic [DW-1:0] REQ1_D, RSP1_D;
  logic          RAM_WE, BUSY;
  logic [AW-1:0] RAM_A;
  logic [DW-1:0] RAM_D, RAM_O;

  xilinx_spdistram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .WCLK(WCLK), .RST_N(RST_N),
    .REQ0_VALID(REQ0_VALID), .REQ0_READY(REQ0_READY), .REQ0_WE(REQ0_WE),
    .REQ0_A(REQ0_A), .REQ0_D(REQ0_D), .RSP0_VALID(RSP0_VALID), .RSP0_D(RSP0_D),
    .REQ1_VALID(REQ1_VALID), .REQ1_READY(REQ1_READY), .REQ1_WE(REQ1_WE),
    .REQ1_A(REQ1_A), .REQ1_D(REQ1_D), .RSP1_VALID(RSP1_VALID), .RSP1_D(RSP1_D),
    .RAM_WE(RAM_WE), .RAM_A(RAM_A), .RAM_D(RAM_D), .RAM_O(RAM_O), .BUSY(BUSY)
  );

  always #5 WCLK = ~WCLK;

  // distributed RAM model: edge write, asynchronous read
  logic [DW-1:0] mem [2**AW];
  always @(posedge WCLK) if (RAM_WE) mem[RAM_A] <= RAM_D;
  assign RAM_O = mem[RAM_A];

  typedef struct {
    logic          rst_n;
    logic          v0, we0; logic [AW-1:0] a0; logic [DW-1:0] d0;
    logic          v1, we1; logic [AW-1:0] a1; logic [DW-1:0] d1;
    logic          rdy0, rdy1, rv0, rv1;
    logic [DW-1:0] rd0, rd1;
    logic          rwe; logic [AW-1:0] ra; logic [DW-1:0] rd;
  } vec_t;

  vec_t vq[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic rst_n,
                     input logic v0, input logic we0, input int a0, input int d0,
                     input logic v1, input logic we1, input int a1, input int d1,
                     input logic rdy0, input logic rdy1, input logic rv0, input logic rv1,
                     input int rd0, input int rd1, input logic rwe, input int ra, input int rd);
    vec_t v;
    v.rst_n = rst_n;
    v.v0 = v0; v.we0 = we0; v.a0 = AW'(a0); v.d0 = DW'(d0);
    v.v1 = v1; v.we1 = we1; v.a1 = AW'(a1); v.d1 = DW'(d1);
    v.rdy0 = rdy0; v.rdy1 = rdy1; v.rv0 = rv0; v.rv1 = rv1;
    v.rd0 = DW'(rd0); v.rd1 = DW'(rd1);
    v.rwe = rwe; v.ra = AW'(ra); v.rd = DW'(rd);
    vq.push_back(v);
  endtask

  task automatic idle_inputs();
    REQ0_VALID = 0; REQ0_WE = 0; REQ0_A = '0; REQ0_D = '0;
    REQ1_VALID = 0; REQ1_WE = 0; REQ1_A = '0; REQ1_D = '0;
  endtask

  initial begin
    for (int i = 0; i < 2**AW; i++) mem[i] = DW'(8'h40 + i);
    idle_inputs();
    RST_N = 1'b0;
    REQ0_VALID = 1'b1; REQ1_VALID = 1'b1;
    repeat (2) @(posedge WCLK);
    @(negedge WCLK);
    chk("reset_rdy0", REQ0_READY, 0);
    chk("reset_rdy1", REQ1_READY, 0);
    chk("reset_rspv0", RSP0_VALID, 0);
    chk("reset_rspv1", RSP1_VALID, 0);
    chk("reset_rspd0", RSP0_D, 0);
    chk("reset_rspd1", RSP1_D, 0);
    chk("reset_ramwe", RAM_WE, 0);
`ifdef SPDISTRAM_ARB_CLEAR_EN
    chk("reset_busy", BUSY, 1);
    // clear sweep with a read request pending the whole time
    for (int k = 0; k < 2**AW; k++) begin
      @(posedge WCLK); #1;
      RST_N = 1'b1;
      REQ0_VALID = 1'b1; REQ0_WE = 1'b0; REQ0_A = '0; REQ1_VALID = 1'b0;
      @(negedge WCLK);
      chk("clr_busy", BUSY, 1);
      chk("clr_rdy0", REQ0_READY, 0);
      chk("clr_ramwe", RAM_WE, 1);
      chk("clr_rama", RAM_A, k);
      chk("clr_ramd", RAM_D, 0);
    end
    @(posedge WCLK); #1;
    @(negedge WCLK);
    chk("run_busy", BUSY, 0);
    chk("run_rdy0", REQ0_READY, 1);
    chk("run_rama", RAM_A, 0);
    @(posedge WCLK); #1; REQ0_A = 6'd31;
    @(negedge WCLK);
    chk("clr_rd0_v", RSP0_VALID, 1);
    chk("clr_rd0_d", RSP0_D, 0);
    @(posedge WCLK); #1; REQ0_A = 6'd63;
    @(negedge WCLK);
    chk("clr_rd31_v", RSP0_VALID, 1);
    chk("clr_rd31_d", RSP0_D, 0);
    @(posedge WCLK); #1; REQ0_VALID = 1'b0;
    @(negedge WCLK);
    chk("clr_rd63_v", RSP0_VALID, 1);
    chk("clr_rd63_d", RSP0_D, 0);
`else
    chk("reset_busy", BUSY, 0);
    idle_inputs();
    //   rst v0 we0 a0  d0    v1 we1 a1  d1    rdy0 rdy1 rv0 rv1 rd0    rd1    rwe ra  rd
    // write then read-back by req0
    add(1,  1, 1,  5,  'hA5, 0, 0,  0,  0,    1, 0, 0, 0, 'h00, 'h00, 1,  5, 'hA5);
    add(1,  1, 0,  5,  0,    0, 0,  0,  0,    1, 0, 0, 0, 'h00, 'h00, 0,  5, 0);
    add(1,  0, 0,  0,  0,    0, 0,  0,  0,    0, 0, 1, 0, 'hA5, 'h00, 0,  5, 0);
    add(0,  0, 0,  0,  0,    0, 0,  0,  0,    0, 0, 0, 0, 'h00, 'h00, 0,  0, 0);
    // both requesters reading every cycle: grants alternate 0,1,0,1,0,1
    add(1,  1, 0, 10,  0,    1, 0, 20,  0,    1, 0, 0, 0, 'h00, 'h00, 0, 10, 0);
    add(1,  1, 0, 11,  0,    1, 0, 20,  0,    0, 1, 1, 0, 'h4A, 'h00, 0, 20, 0);
    add(1,  1, 0, 11,  0,    1, 0, 21,  0,    1, 0, 0, 1, 'h4A, 'h54, 0, 11, 0);
    add(1,  1, 0, 12,  0,    1, 0, 21,  0,    0, 1, 1, 0, 'h4B, 'h54, 0, 21, 0);
    add(1,  1, 0, 12,  0,    1, 0, 22,  0,    1, 0, 0, 1, 'h4B, 'h55, 0, 12, 0);
    add(1,  1, 0, 13,  0,    1, 0, 22,  0,    0, 1, 1, 0, 'h4C, 'h55, 0, 22, 0);
    add(1,  0, 0,  0,  0,    0, 0,  0,  0,    0, 0, 0, 1, 'h4C, 'h56, 0, 22, 0);
    // req0 read vs req1 write to 63: old data first, new data on re-read
    add(1,  1, 0, 63,  0,    1, 1, 63, 'h3C,  1, 0, 0, 0, 'h4C, 'h56, 0, 63, 0);
    add(1,  1, 0, 63,  0,    1, 1, 63, 'h3C,  0, 1, 1, 0, 'h7F, 'h56, 1, 63, 'h3C);
    add(1,  1, 0, 63,  0,    0, 0,  0,  0,    1, 0, 0, 0, 'h7F, 'h56, 0, 63, 0);
    add(1,  0, 0,  0,  0,    0, 0,  0,  0,    0, 0, 1, 0, 'h3C, 'h56, 0, 63, 0);
    // req1 alone for four cycles, then a tie goes to req0
    add(1,  0, 0,  0,  0,    1, 0,  1,  0,    0, 1, 0, 0, 'h3C, 'h56, 0,  1, 0);
    add(1,  0, 0,  0,  0,    1, 0,  2,  0,    0, 1, 0, 1, 'h3C, 'h41, 0,  2, 0);
    add(1,  0, 0,  0,  0,    1, 0,  3,  0,    0, 1, 0, 1, 'h3C, 'h42, 0,  3, 0);
    add(1,  0, 0,  0,  0,    1, 0,  4,  0,    0, 1, 0, 1, 'h3C, 'h43, 0,  4, 0);
    add(1,  1, 0,  6,  0,    1, 0,  7,  0,    1, 0, 0, 1, 'h3C, 'h44, 0,  6, 0);
    add(1,  0, 0,  0,  0,    1, 0,  7,  0,    0, 1, 1, 0, 'h46, 'h44, 0,  7, 0);
    add(1,  0, 0,  0,  0,    0, 0,  0,  0,    0, 0, 0, 1, 'h46, 'h47, 0,  7, 0);
    // reset right after a read grant drops the response; RAM keeps its data
    add(1,  1, 0,  5,  0,    0, 0,  0,  0,    1, 0, 0, 0, 'h46, 'h47, 0,  5, 0);
    add(0,  0, 0,  0,  0,    0, 0,  0,  0,    0, 0, 0, 0, 'h00, 'h00, 0,  0, 0);
    add(1,  0, 0,  0,  0,    0, 0,  0,  0,    0, 0, 0, 0, 'h00, 'h00, 0,  0, 0);
    add(1,  1, 0,  5,  0,    0, 0,  0,  0,    1, 0, 0, 0, 'h00, 'h00, 0,  5, 0);
    add(1,  0, 0,  0,  0,    0, 0,  0,  0,    0, 0, 1, 0, 'hA5, 'h00, 0,  5, 0);

    foreach (vq[i]) begin
      @(posedge WCLK); #1;
      RST_N      = vq[i].rst_n;
      REQ0_VALID = vq[i].v0; REQ0_WE = vq[i].we0; REQ0_A = vq[i].a0; REQ0_D = vq[i].d0;
      REQ1_VALID = vq[i].v1; REQ1_WE = vq[i].we1; REQ1_A = vq[i].a1; REQ1_D = vq[i].d1;
      @(negedge WCLK);
      chk($sformatf("v%0d_rdy0", i), REQ0_READY, vq[i].rdy0);
      chk($sformatf("v%0d_rdy1", i), REQ1_READY, vq[i].rdy1);
      chk($sformatf("v%0d_rspv0", i), RSP0_VALID, vq[i].rv0);
      chk($sformatf("v%0d_rspv1", i), RSP1_VALID, vq[i].rv1);
      chk($sformatf("v%0d_rspd0", i), RSP0_D, vq[i].rd0);
      chk($sformatf("v%0d_rspd1", i), RSP1_D, vq[i].rd1);
      chk($sformatf("v%0d_ramwe", i), RAM_WE, vq[i].rwe);
      chk($sformatf("v%0d_rama", i), RAM_A, vq[i].ra);
      chk($sformatf("v%0d_ramd", i), RAM_D, vq[i].rd);
      chk($sformatf("v%0d_busy", i), BUSY, 0);
    end
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
